// File: rtl/cache_assoc.sv
// N-way set-associative, write-back, write-allocate cache with age-based LRU.
// Processor side: word-addressed read/write with combinational stall.
// Memory side: block-wide read/write with a single-cycle ready handshake.
// Handshake: the processor holds its request, address and write data while
// proc_stall=1; the cache holds mem_read/mem_write, mem_addr and mem_wdata
// until mem_ready=1 is sampled at a clock edge, then drops them next cycle.
module cache_assoc #(
  parameter int WAYS        = 2,
  parameter int SETS        = 8,
  parameter int BLOCK_WORDS = 4,
  localparam int OFF_W = $clog2(BLOCK_WORDS),
  localparam int IDX_W = $clog2(SETS),
  localparam int TAG_W = 30 - IDX_W - OFF_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      proc_read,
  input  logic                      proc_write,
  input  logic [29:0]               proc_addr,
  input  logic [31:0]               proc_wdata,
  output logic [31:0]               proc_rdata,
  output logic                      proc_stall,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [29-OFF_W:0]         mem_addr,
  output logic [32*BLOCK_WORDS-1:0] mem_wdata,
  input  logic [32*BLOCK_WORDS-1:0] mem_rdata,
  input  logic                      mem_ready
);

  // Age and way-index width; a 1-way cache still keeps a 1-bit (always 0) age.
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BLK_W = 30 - OFF_W;

  typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t state_q, state_d;

  logic [31:0]      data_q  [WAYS][SETS][BLOCK_WORDS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [AGE_W-1:0] age_q   [WAYS][SETS];

  // Victim way and missing block address, captured when a miss is detected
  // so the memory transaction stays consistent even if the request drops.
  logic [AGE_W-1:0] vic_q;
  logic [BLK_W-1:0] blk_q;

  logic             req;
  logic [TAG_W-1:0] tag_f;
  logic [IDX_W-1:0] idx_f;
  logic [OFF_W-1:0] off_f;
  logic [IDX_W-1:0] blk_idx;
  logic [TAG_W-1:0] blk_tag;
  logic             hit;
  logic [AGE_W-1:0] hit_way;
  logic [AGE_W-1:0] victim;

  assign req     = proc_read | proc_write;
  assign tag_f   = proc_addr[29 -: TAG_W];
  assign idx_f   = proc_addr[OFF_W +: IDX_W];
  assign off_f   = proc_addr[OFF_W-1:0];
  assign blk_idx = blk_q[IDX_W-1:0];
  assign blk_tag = blk_q[BLK_W-1 -: TAG_W];

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx_f][w] && (tag_q[w][idx_f] == tag_f)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
  end

  // Victim: lowest-index invalid way, otherwise the oldest (LRU) way.
  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[w][idx_f] == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx_f][w]) victim = AGE_W'(w);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COMPARE;
    else        state_q <= state_d;
  end

  // Next state and all outputs; outputs are held quiet while reset is low.
  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    proc_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      COMPARE: begin
        if (req && hit) begin
          proc_rdata = data_q[hit_way][idx_f][off_f];
        end else if (req && rst_n) begin
          proc_stall = 1'b1;
          state_d    = (valid_q[idx_f][victim] && dirty_q[idx_f][victim])
                       ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {tag_q[vic_q][blk_idx], blk_idx};
        for (int k = 0; k < BLOCK_WORDS; k++) begin
          mem_wdata[32*k +: 32] = data_q[vic_q][blk_idx][k];
        end
        if (mem_ready) state_d = req ? ALLOCATE : COMPARE;
      end
      ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = blk_q;
        if (mem_ready) state_d = COMPARE;
      end
      default: state_d = COMPARE;
    endcase
  end

  // Capture victim and block address on the miss cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vic_q <= '0;
      blk_q <= '0;
    end else if (state_q == COMPARE && req && !hit) begin
      vic_q <= victim;
      blk_q <= proc_addr[29:OFF_W];
    end
  end

  // Valid, dirty and LRU age bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[w][s] <= AGE_W'(w);
      end
    end else begin
      case (state_q)
        COMPARE: begin
          if (req && hit) begin
            if (proc_write) dirty_q[idx_f][hit_way] <= 1'b1;
            for (int w = 0; w < WAYS; w++) begin
              if (AGE_W'(w) == hit_way) age_q[w][idx_f] <= '0;
              else if (age_q[w][idx_f] < age_q[hit_way][idx_f])
                age_q[w][idx_f] <= age_q[w][idx_f] + 1'b1;
            end
          end
        end
        WRITEBACK: if (mem_ready) dirty_q[blk_idx][vic_q] <= 1'b0;
        ALLOCATE: begin
          if (mem_ready) begin
            valid_q[blk_idx][vic_q] <= 1'b1;
            dirty_q[blk_idx][vic_q] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Data and tag arrays: write hits merge a word, fills replace the block.
  always_ff @(posedge clk) begin
    if (state_q == COMPARE && proc_write && hit) begin
      data_q[hit_way][idx_f][off_f] <= proc_wdata;
    end else if (state_q == ALLOCATE && mem_ready) begin
      tag_q[vic_q][blk_idx] <= blk_tag;
      for (int k = 0; k < BLOCK_WORDS; k++) begin
        data_q[vic_q][blk_idx][k] <= mem_rdata[32*k +: 32];
      end
    end
  end

endmodule

// File: doc/cache_assoc.md
Name: cache_assoc

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache with LRU replacement.
- Processor side uses the word-addressed read/write/stall interface already used by the I/D caches in the CHIP top.
- Memory side uses the block-wide slow-memory interface with a ready handshake.
- Drop-in successor to the direct-mapped cache for both the I and D instances; associativity, depth and block size are configurable.

Parameters:
WAYS, 2, associativity; legal values 1, 2, 4
SETS, 8, number of sets; power of 2, at least 2
BLOCK_WORDS, 4, 32-bit words per block; power of 2, at least 2
OFF_W, log2(BLOCK_WORDS), derived word-offset width
IDX_W, log2(SETS), derived index width
TAG_W, 30-IDX_W-OFF_W, derived tag width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
proc_read  in  1  processor read request
proc_write  in  1  processor write request
proc_addr  in  30  word address: {tag, index, offset}
proc_wdata  in  32  write data
proc_rdata  out  32  read data; valid when proc_read=1 and proc_stall=0
proc_stall  out  1  request not complete; processor holds its request
mem_read  out  1  block fill request
mem_write  out  1  block writeback request
mem_addr  out  30-OFF_W  block address
mem_wdata  out  32*BLOCK_WORDS  writeback block; word 0 in bits [31:0]
mem_rdata  in  32*BLOCK_WORDS  fill block; word 0 in bits [31:0]
mem_ready  in  1  memory completes the current mem_read or mem_write

Behaviour:
- Reset (asynchronous): all valid and dirty bits cleared, LRU state cleared, FSM forced to COMPARE.
- Outputs during and after reset: proc_stall=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, proc_rdata=0. Data and tag arrays need not be reset.
- Requests: req = proc_read | proc_write. Both asserted is illegal; the block treats it as a write.
- Hit: a way in the selected set is valid and its tag matches.
- States: COMPARE, WRITEBACK, ALLOCATE.
- COMPARE, no request: proc_stall=0; no state change.
- COMPARE, hit:
  - proc_stall=0 in the same cycle; proc_rdata is combinational from the hitting way and word.
  - A write updates the word at the clock edge and sets the way's dirty bit.
  - The hitting way becomes MRU for its set.
- COMPARE, miss:
  - proc_stall=1 combinationally.
  - Victim selection: lowest-index invalid way; if none is invalid, the LRU way.
  - Victim valid and dirty: next state WRITEBACK. Otherwise: next state ALLOCATE.
- WRITEBACK:
  - mem_write=1; mem_addr = {victim tag, index}; mem_wdata = victim block.
  - These stay stable until mem_ready=1 is sampled at a clock edge; then victim dirty is cleared and next state is ALLOCATE.
- ALLOCATE:
  - mem_read=1; mem_addr = proc_addr[29:OFF_W].
  - When mem_ready=1 is sampled: victim way is written with mem_rdata, tag set, valid=1, dirty=0; next state COMPARE.
  - The request then hits in COMPARE, and any write merges there.
- proc_stall=1 in every cycle spent in WRITEBACK or ALLOCATE.
- mem_read and mem_write are never both 1. Both deassert in the cycle after mem_ready is accepted.
- LRU:
  - Each set holds a log2(WAYS)-bit age per way. Reset ages are way index (way 0 youngest).
  - On an access, the touched way's age goes to 0; ways younger than its old age increment by 1.
  - Ages remain a permutation of 0..WAYS-1 at all times.
  - WAYS=1: no LRU state; the victim is always way 0.
- Processor contract: the processor holds proc_addr, proc_wdata and request stable while proc_stall=1. The block does not latch the request.
- Request dropped mid-miss: the memory transaction in flight completes; the FSM returns to COMPARE; no processor-visible write occurs.
- Reset asserted mid-transaction: immediate abort; all lines are invalidated, and the memory side must tolerate the dropped request.
- mem_ready while in COMPARE is ignored.
- Miss latency: clean miss = fill latency + 1 cycle (COMPARE re-hit). Dirty miss = writeback latency + fill latency + 1.

Test Plan (WAYS=2, SETS=8, BLOCK_WORDS=4, memory ready 4 cycles after request):
1. After reset, read 0x0000010 -> proc_stall=1; mem_read=1 with mem_addr=0x0000004; mem_write never asserted. After mem_ready, the next cycle gives proc_stall=0 and proc_rdata = word 0 of the fill.
2. Write 0xDEADBEEF to 0x0000011 (hit), then read 0x0000011 -> each completes with zero stall cycles; readback = 0xDEADBEEF; no memory traffic.
3. Read 0x0000010, then 0x0000030 (same set 4, different tag) -> both are filled into ways 0 and 1 without writeback. Re-reads of both hit.
4. After 2 and 3 (0x0000010 is LRU after the 0x0000030 access), read 0x0000050:
   - mem_write=1 first, with mem_addr=0x0000004 and mem_wdata[63:32]=0xDEADBEEF.
   - Then mem_read=1 with mem_addr=0x0000014.
   - 0x0000030 is still a hit afterwards.
5. Assert rst_n=0 while in ALLOCATE with mem_read=1 -> mem_read=0 and proc_stall=0 immediately; read 0x0000030 afterwards misses.
6. Random mixed reads and writes over 64 addresses, checked against a flat reference memory -> zero data mismatches; mem_read and mem_write never both high; request signals held while stalled.
